// File: rtl/sg_elem_reader_256_if.sv
// Bus between the SG data buffer, the element reader and the TX port writer.
// The slave modport is the reader's view; the master modport drives it.
interface sg_elem_reader_256_if #(
  parameter int C_DATA_WIDTH = 256
);
  logic [C_DATA_WIDTH-1:0] BUF_DATA;
  logic                    BUF_DATA_EMPTY;
  logic                    BUF_DATA_REN;
  logic                    VALID;
  logic                    EMPTY;
  logic                    REN;
  logic [63:0]             ADDR;
  logic [31:0]             LEN;

  modport slave (
    input  BUF_DATA, BUF_DATA_EMPTY, REN,
    output BUF_DATA_REN, VALID, EMPTY, ADDR, LEN
  );

  modport master (
    output BUF_DATA, BUF_DATA_EMPTY, REN,
    input  BUF_DATA_REN, VALID, EMPTY, ADDR, LEN
  );
endinterface

// File: rtl/sg_elem_reader_256.sv
// Pops one 256-bit SG word at a time and presents it as a 64-bit address and
// 32-bit length. It holds at most one element and prefetches the next once it is consumed.
module sg_elem_reader_256 #(
  parameter int C_DATA_WIDTH = 256
) (
  input logic                 CLK,
  input logic                 RST,
  sg_elem_reader_256_if.slave bus
);

  typedef enum logic {RD_FETCH, RD_WAIT} rd_state_e;
  typedef enum logic {CAP_IDLE, CAP_RDY} cap_state_e;

  rd_state_e   rd_q, rd_d;
  cap_state_e  cap_q, cap_d;
  logic        inflight_q;
  logic        valid_q, valid_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] len_q, len_d;
  logic        pop;
  logic        unused_hi;

  // Bits above the length field carry nothing this block uses.
  assign unused_hi = ^bus.BUF_DATA[C_DATA_WIDTH-1:96];

  assign bus.BUF_DATA_REN = (rd_q == RD_FETCH) && !RST;
  assign pop              = bus.BUF_DATA_REN && !bus.BUF_DATA_EMPTY;

  assign bus.VALID = valid_q;
  assign bus.ADDR  = addr_q;
  assign bus.LEN   = len_q;
  assign bus.EMPTY = bus.BUF_DATA_EMPTY && (rd_q == RD_FETCH);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    rd_d    = rd_q;
    cap_d   = cap_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    len_d   = len_q;

    case (rd_q)
      RD_FETCH: if (pop) rd_d = RD_WAIT;
      RD_WAIT:  if (bus.REN && valid_q) rd_d = RD_FETCH;
      default:  rd_d = RD_FETCH;
    endcase

    // The word popped last edge is on BUF_DATA now; capture it only then.
    case (cap_q)
      CAP_IDLE: if (inflight_q) begin
        addr_d  = bus.BUF_DATA[63:0];
        len_d   = bus.BUF_DATA[95:64];
        valid_d = 1'b1;
        cap_d   = CAP_RDY;
      end
      CAP_RDY: if (bus.REN) begin
        valid_d = 1'b0;
        cap_d   = CAP_IDLE;
      end
      default: cap_d = CAP_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // from the same pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_q       <= RD_FETCH;
      cap_q      <= CAP_IDLE;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
    end else begin
      rd_q       <= rd_d;
      cap_q      <= cap_d;
      inflight_q <= pop;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
    end
  end

endmodule

// File: tb/tb_sg_elem_reader_256.sv
// Directed bench for sg_elem_reader_256: a small FIFO model feeds SG words and
// outputs are checked on the falling edge against hand-computed values.
module tb_sg_elem_reader_256;

  logic CLK = 1'b0;
  logic RST;

  sg_elem_reader_256_if #(.C_DATA_WIDTH(256)) bus ();

  sg_elem_reader_256 #(.C_DATA_WIDTH(256)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // SG buffer model: pop at an edge with REN=1 and not empty, data the cycle
  // after; junk on BUF_DATA whenever no pop happened.
  logic [255:0] mem [16];
  int wr_ptr    = 0;
  int rd_ptr    = 0;
  int pop_count = 0;

  assign bus.BUF_DATA_EMPTY = (rd_ptr == wr_ptr);

  always @(posedge CLK) begin
    if (bus.BUF_DATA_REN && !bus.BUF_DATA_EMPTY) begin
      bus.BUF_DATA <= mem[rd_ptr[3:0]];
      rd_ptr       <= rd_ptr + 1;
      pop_count    <= pop_count + 1;
    end else begin
      bus.BUF_DATA <= {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [63:0] addr, input logic [31:0] len);
    mem[wr_ptr[3:0]] = {{5{32'hA5A5_5A5A}}, len, addr};
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  localparam logic [63:0] A0 = 64'h0000_0001_DEAD_BEE0;
  localparam logic [31:0] L0 = 32'h400;
  localparam logic [63:0] A1 = 64'h1234_5678_9ABC_DEF0;
  localparam logic [31:0] L1 = 32'h10;

  logic [63:0] b2b_addr [3];
  logic [31:0] b2b_len  [3];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    b2b_addr[0] = 64'h0000_0000_0000_1000; b2b_len[0] = 32'h1;
    b2b_addr[1] = 64'hFFFF_FFFF_FFFF_FFFC; b2b_len[1] = 32'hFFFF_FFFF;
    b2b_addr[2] = 64'h8000_0002_4000_0008; b2b_len[2] = 32'h80;

    // Reset with a word already queued: no pop may happen while RST is high.
    RST     = 1'b1;
    bus.REN = 1'b0;
    push(A0, L0);
    tick();
    check("rst_buf_ren_c1", 64'(bus.BUF_DATA_REN), 64'd0);
    tick();
    check("rst_buf_ren_c2", 64'(bus.BUF_DATA_REN), 64'd0);
    check("rst_valid", 64'(bus.VALID), 64'd0);
    check("rst_addr", bus.ADDR, 64'd0);
    check("rst_len", 64'(bus.LEN), 64'd0);
    check("rst_no_pop", 64'(pop_count), 64'd0);
    RST = 1'b0;
    #1;
    check("post_rst_buf_ren", 64'(bus.BUF_DATA_REN), 64'd1);
    check("post_rst_empty", 64'(bus.EMPTY), 64'd0);

    // Single element: pop edge, then capture one edge later.
    tick();
    check("single_pop", 64'(pop_count), 64'd1);
    check("single_inflight_valid", 64'(bus.VALID), 64'd0);
    check("single_inflight_empty", 64'(bus.EMPTY), 64'd0);
    check("single_wait_buf_ren", 64'(bus.BUF_DATA_REN), 64'd0);
    tick();
    check("single_valid", 64'(bus.VALID), 64'd1);
    check("single_addr", bus.ADDR, A0);
    check("single_len", 64'(bus.LEN), 64'(L0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_valid_%0d", i), 64'(bus.VALID), 64'd1);
      check($sformatf("hold_addr_%0d", i), bus.ADDR, A0);
      check($sformatf("hold_len_%0d", i), 64'(bus.LEN), 64'(L0));
      check($sformatf("hold_buf_ren_%0d", i), 64'(bus.BUF_DATA_REN), 64'd0);
    end
    check("single_one_pop", 64'(pop_count), 64'd1);

    // Drain the last element with the buffer empty.
    bus.REN = 1'b1;
    tick();
    bus.REN = 1'b0;
    check("drain_valid", 64'(bus.VALID), 64'd0);
    check("drain_empty", 64'(bus.EMPTY), 64'd1);
    check("drain_addr_kept", bus.ADDR, A0);

    // Spurious REN while nothing is held, then a word arrives.
    bus.REN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("spur_valid_%0d", i), 64'(bus.VALID), 64'd0);
    end
    check("spur_no_pop", 64'(pop_count), 64'd1);
    push(A1, L1);
    #1;
    check("spur_empty_arrive", 64'(bus.EMPTY), 64'd0);
    tick();
    check("spur_pop", 64'(pop_count), 64'd2);
    check("spur_inflight_valid", 64'(bus.VALID), 64'd0);
    tick();
    check("spur_valid", 64'(bus.VALID), 64'd1);
    check("spur_addr", bus.ADDR, A1);
    check("spur_len", 64'(bus.LEN), 64'(L1));
    tick();
    check("spur_consumed", 64'(bus.VALID), 64'd0);
    check("spur_empty_after", 64'(bus.EMPTY), 64'd1);
    check("spur_pop_once", 64'(pop_count), 64'd2);

    // Back-to-back with REN held: VALID on cycles 2, 5, 8 after the push.
    for (int k = 0; k < 3; k++) push(b2b_addr[k], b2b_len[k]);
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c % 3 == 2) begin
        check($sformatf("b2b_valid_c%0d", c), 64'(bus.VALID), 64'd1);
        check($sformatf("b2b_addr_c%0d", c), bus.ADDR, b2b_addr[c/3]);
        check($sformatf("b2b_len_c%0d", c), 64'(bus.LEN), 64'(b2b_len[c/3]));
      end else begin
        check($sformatf("b2b_valid_c%0d", c), 64'(bus.VALID), 64'd0);
      end
    end
    bus.REN = 1'b0;
    check("b2b_pops", 64'(pop_count), 64'd5);
    check("b2b_empty", 64'(bus.EMPTY), 64'd1);

    // Reset while an element is held; the next queued word follows normally.
    push(64'h0000_00AA_0000_0100, 32'h20);
    tick();
    tick();
    check("mid_valid_before", 64'(bus.VALID), 64'd1);
    check("mid_addr_before", bus.ADDR, 64'h0000_00AA_0000_0100);
    push(64'h0000_00BB_0000_0200, 32'h30);
    RST = 1'b1;
    #1;
    check("mid_rst_buf_ren", 64'(bus.BUF_DATA_REN), 64'd0);
    tick();
    check("mid_rst_valid", 64'(bus.VALID), 64'd0);
    check("mid_rst_addr", bus.ADDR, 64'd0);
    check("mid_rst_len", 64'(bus.LEN), 64'd0);
    check("mid_rst_no_pop", 64'(pop_count), 64'd6);
    RST = 1'b0;
    #1;
    check("mid_post_buf_ren", 64'(bus.BUF_DATA_REN), 64'd1);
    tick();
    check("mid_post_pop", 64'(pop_count), 64'd7);
    tick();
    check("mid_post_valid", 64'(bus.VALID), 64'd1);
    check("mid_post_addr", bus.ADDR, 64'h0000_00BB_0000_0200);
    check("mid_post_len", 64'(bus.LEN), 64'h30);
    bus.REN = 1'b1;
    tick();
    bus.REN = 1'b0;
    check("final_valid", 64'(bus.VALID), 64'd0);
    check("final_empty", 64'(bus.EMPTY), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
